// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the board SRAM front-end.
// Holds the controller state encoding and the default geometry / clear value.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 11;
    localparam int SRAM_DATA_W = 8;
    localparam logic [SRAM_DATA_W-1:0] SRAM_CLEAR_VAL = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ACC,
        S_RD_CAP,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
    } sram_state_t;

endpackage

// File: rtl/sram_cycle_timer.sv
// Loadable down-counter used to time the read access and write pulse phases.
// o_done is high while the count sits at zero.
module sram_cycle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous front-end for the asynchronous board SRAM: sequences CS/OE/RnW strobes
// for single reads and writes, and runs a full-memory clear sweep.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int                 ADDR_W    = SRAM_ADDR_W,
    parameter int                 DATA_W    = SRAM_DATA_W,
    parameter int                 RD_WAIT   = 2,
    parameter int                 WR_PULSE  = 2,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = DATA_W'(SRAM_CLEAR_VAL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clear_start,
    output logic              clear_busy,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_oe_n,
    output logic              sram_rw_n,
    output logic              sram_cs_n
);

    localparam int MAX_WAIT = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
    localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

    sram_state_t       r_state;
    sram_state_t       w_next;
    logic              w_tmr_load;
    logic [CNT_W-1:0]  w_tmr_val;
    logic              w_tmr_done;
    logic              w_accept;
    logic              w_clr_go;
    logic              w_clr_step;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_ready;
    logic              r_clear_busy;
    logic              r_cs_n;
    logic              r_oe_n;
    logic              r_rw_n;
    logic              r_bus_oe;

    sram_cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_accept   = 1'b0;
        w_clr_go   = 1'b0;
        w_clr_step = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear_start) begin
                    w_clr_go = 1'b1;
                    w_next   = S_WR_SETUP;
                end else if (req_valid) begin
                    w_accept = 1'b1;
                    if (req_write) begin
                        w_next = S_WR_SETUP;
                    end else begin
                        w_next     = S_RD_ACC;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = CNT_W'(RD_WAIT - 1);
                    end
                end
            end
            S_RD_ACC: begin
                if (w_tmr_done) begin
                    w_next = S_RD_CAP;
                end
            end
            S_RD_CAP: begin
                w_next = S_IDLE;
            end
            S_WR_SETUP: begin
                w_next     = S_WR_PULSE;
                w_tmr_load = 1'b1;
                w_tmr_val  = CNT_W'(WR_PULSE - 1);
            end
            S_WR_PULSE: begin
                if (w_tmr_done) begin
                    w_next = S_WR_HOLD;
                end
            end
            S_WR_HOLD: begin
                // The sweep chains straight into the next address; it stops on the all-ones address.
                if (r_clear_busy && !(&r_addr)) begin
                    w_clr_step = 1'b1;
                    w_next     = S_WR_SETUP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Strobes and bus enable are registered from the next state so the pins never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready      <= 1'b1;
            r_cs_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_rw_n       <= 1'b1;
            r_bus_oe     <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_clear_busy <= 1'b0;
        end else begin
            r_ready    <= (w_next == S_IDLE);
            r_cs_n     <= (w_next == S_IDLE);
            r_oe_n     <= !((w_next == S_RD_ACC) || (w_next == S_RD_CAP));
            r_rw_n     <= (w_next != S_WR_PULSE);
            r_bus_oe   <= (w_next == S_WR_SETUP) || (w_next == S_WR_PULSE) ||
                          (w_next == S_WR_HOLD);
            r_rd_valid <= (r_state == S_RD_CAP);
            if (r_state == S_RD_CAP) begin
                r_rd_data <= sram_data;
            end
            if (w_clr_go) begin
                r_addr       <= '0;
                r_wdata      <= CLEAR_VAL;
                r_clear_busy <= 1'b1;
            end else if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end else if (w_clr_step) begin
                r_addr <= r_addr + 1'b1;
            end
            if ((r_state == S_WR_HOLD) && (w_next == S_IDLE)) begin
                r_clear_busy <= 1'b0;
            end
        end
    end

    assign sram_data  = r_bus_oe ? r_wdata : {DATA_W{1'bz}};
    assign sram_addr  = r_addr;
    assign sram_cs_n  = r_cs_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_rw_n  = r_rw_n;
    assign req_ready  = r_ready;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
    assign clear_busy = r_clear_busy;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl driving a behavioural asynchronous 2048x8 SRAM model.
module tb_sram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [10:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        clear_start;
    logic        clear_busy;
    wire  [7:0]  sram_data;
    logic [10:0] sram_addr;
    logic        sram_oe_n;
    logic        sram_rw_n;
    logic        sram_cs_n;

    int checks;
    int errors;

    logic [7:0] mem [0:2047];

    sram_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .sram_data   (sram_data),
        .sram_addr   (sram_addr),
        .sram_oe_n   (sram_oe_n),
        .sram_rw_n   (sram_rw_n),
        .sram_cs_n   (sram_cs_n)
    );

    // Asynchronous SRAM: drives the bus on CS&OE with RnW high, commits on the rising RnW edge.
    assign sram_data = (!sram_cs_n && !sram_oe_n && sram_rw_n) ? mem[sram_addr] : 8'hzz;

    always @(posedge sram_rw_n) begin
        if (sram_cs_n == 1'b0) begin
            mem[sram_addr] = sram_data;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s wait_ready timeout: req_ready=%b required 1", tag, req_ready);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [10:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic do_write(input logic [10:0] a, input logic [7:0] d);
        wait_ready("do_write");
        applyStimulus(1'b1, a, d);
        @(negedge clk);
        req_valid = 1'b0;
        wait_ready("do_write_done");
    endtask

    // Issues one read and watches 8 cycles: latency in edges after accept, pulse count, data.
    task automatic do_read(input logic [10:0] a, output logic [7:0] data,
                           output int lat, output int pulses);
        wait_ready("do_read");
        applyStimulus(1'b0, a, 8'h00);
        lat    = -1;
        pulses = 0;
        data   = 8'hxx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (rd_valid === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat  = k - 1;
                    data = rd_data;
                end
            end
        end
    endtask

    task automatic test_reset;
        #12;
        checks += 9;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", req_ready); end
        if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid got %b want 0", rd_valid); end
        if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data got %h want 00", rd_data); end
        if (clear_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_clear_busy got %b want 0", clear_busy); end
        if (sram_addr !== 11'h000) begin errors++; $display("[TB] FAIL reset_addr got %h want 000", sram_addr); end
        if (sram_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs_n got %b want 1", sram_cs_n); end
        if (sram_oe_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_oe_n got %b want 1", sram_oe_n); end
        if (sram_rw_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_rw_n got %b want 1", sram_rw_n); end
        if (dut.r_bus_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_drive got %b want 0", dut.r_bus_oe); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        logic [7:0] d;
        int lat, pulses;
        do_write(11'h123, 8'hA5);
        do_read(11'h123, d, lat, pulses);
        checks += 3;
        if (d !== 8'hA5) begin errors++; $display("[TB] FAIL wr_rd_data got %h want a5", d); end
        if (lat != 3) begin errors++; $display("[TB] FAIL wr_rd_latency got %0d want 3", lat); end
        if (pulses != 1) begin errors++; $display("[TB] FAIL wr_rd_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_extremes;
        logic [7:0] d;
        int lat, pulses;
        do_write(11'h7FF, 8'h3C);
        do_write(11'h000, 8'hC3);
        do_read(11'h7FF, d, lat, pulses);
        checks++;
        if (d !== 8'h3C) begin errors++; $display("[TB] FAIL extreme_7ff got %h want 3c", d); end
        do_read(11'h000, d, lat, pulses);
        checks++;
        if (d !== 8'hC3) begin errors++; $display("[TB] FAIL extreme_000 got %h want c3", d); end
    endtask

    task automatic test_write_strobes;
        int rw_lo, cs_lo, oe_lo, rdy_lo, drv_cs_lo, drv_cs_hi, bad_data;
        rw_lo = 0; cs_lo = 0; oe_lo = 0; rdy_lo = 0; drv_cs_lo = 0; drv_cs_hi = 0; bad_data = 0;
        wait_ready("strobes");
        applyStimulus(1'b1, 11'h2AA, 8'h96);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (sram_rw_n === 1'b0) rw_lo++;
            if (sram_cs_n === 1'b0) cs_lo++;
            if (sram_oe_n === 1'b0) oe_lo++;
            if (req_ready === 1'b0) rdy_lo++;
            if (dut.r_bus_oe === 1'b1 && sram_cs_n === 1'b0) drv_cs_lo++;
            if (dut.r_bus_oe === 1'b1 && sram_cs_n !== 1'b0) drv_cs_hi++;
            if (sram_cs_n === 1'b0 && (sram_data !== 8'h96 || sram_addr !== 11'h2AA)) bad_data++;
        end
        checks += 7;
        if (rw_lo != 2) begin errors++; $display("[TB] FAIL wr_rw_low got %0d want 2", rw_lo); end
        if (cs_lo != 4) begin errors++; $display("[TB] FAIL wr_cs_low got %0d want 4", cs_lo); end
        if (oe_lo != 0) begin errors++; $display("[TB] FAIL wr_oe_low got %0d want 0", oe_lo); end
        if (rdy_lo != 4) begin errors++; $display("[TB] FAIL wr_ready_low got %0d want 4", rdy_lo); end
        if (drv_cs_lo != 4) begin errors++; $display("[TB] FAIL wr_drive_cs_low got %0d want 4", drv_cs_lo); end
        if (drv_cs_hi != 0) begin errors++; $display("[TB] FAIL wr_drive_cs_high got %0d want 0", drv_cs_hi); end
        if (bad_data != 0) begin errors++; $display("[TB] FAIL wr_bus_addr_data got %0d bad cycles want 0", bad_data); end
    endtask

    task automatic test_back_to_back;
        logic [10:0] addrs [3];
        logic [7:0]  exp   [3];
        int issued, got, bursts;
        logic prev_cs;
        addrs[0] = 11'h123; exp[0] = 8'hA5;
        addrs[1] = 11'h7FF; exp[1] = 8'h3C;
        addrs[2] = 11'h000; exp[2] = 8'hC3;
        issued = 0; got = 0; bursts = 0;
        wait_ready("b2b");
        prev_cs = sram_cs_n;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) @(negedge clk);
            if (prev_cs === 1'b1 && sram_cs_n === 1'b0) bursts++;
            prev_cs = sram_cs_n;
            if (rd_valid === 1'b1) begin
                if (got < 3) begin
                    checks++;
                    if (rd_data !== exp[got]) begin
                        errors++;
                        $display("[TB] FAIL b2b_data[%0d] got %h want %h", got, rd_data, exp[got]);
                    end
                end
                got++;
            end
            if (req_ready === 1'b1) begin
                if (issued < 3) begin
                    applyStimulus(1'b0, addrs[issued], 8'h00);
                    issued++;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        checks += 2;
        if (got != 3) begin errors++; $display("[TB] FAIL b2b_pulses got %0d want 3", got); end
        if (bursts != 3) begin errors++; $display("[TB] FAIL b2b_cs_bursts got %0d want 3", bursts); end
    endtask

    task automatic test_clear;
        int k, busy_cnt, rdv;
        logic [7:0] d;
        int lat, pulses;
        k = 0; busy_cnt = 0; rdv = 0;
        wait_ready("clear");
        applyStimulus(1'b1, 11'h400, 8'h77);
        clear_start = 1'b1;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                req_valid   = 1'b0;
                clear_start = 1'b0;
                checks += 2;
                if (clear_busy !== 1'b1) begin errors++; $display("[TB] FAIL clear_wins_busy got %b want 1", clear_busy); end
                if (sram_addr !== 11'h000) begin errors++; $display("[TB] FAIL clear_first_addr got %h want 000", sram_addr); end
            end
            if (clear_busy === 1'b1) busy_cnt++;
            if (rd_valid === 1'b1) rdv++;
        end while (clear_busy === 1'b1 && k < 9000);
        checks += 3;
        if (busy_cnt != 8192) begin errors++; $display("[TB] FAIL clear_duration got %0d want 8192", busy_cnt); end
        if (rdv != 0) begin errors++; $display("[TB] FAIL clear_rd_valid got %0d want 0", rdv); end
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL clear_ready_after got %b want 1", req_ready); end
        do_read(11'h000, d, lat, pulses);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL clear_rd_000 got %h want 00", d); end
        do_read(11'h400, d, lat, pulses);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL clear_rd_400 got %h want 00", d); end
        do_read(11'h7FF, d, lat, pulses);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL clear_rd_7ff got %h want 00", d); end
    endtask

    task automatic test_reset_mid_read;
        logic [7:0] d;
        int lat, pulses, rdv;
        rdv = 0;
        do_write(11'h055, 8'h5A);
        wait_ready("mid_read");
        applyStimulus(1'b0, 11'h055, 8'h00);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (sram_oe_n !== 1'b0) begin errors++; $display("[TB] FAIL midrd_in_access oe_n got %b want 0", sram_oe_n); end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (sram_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL midrd_cs_n got %b want 1", sram_cs_n); end
        if (sram_oe_n !== 1'b1) begin errors++; $display("[TB] FAIL midrd_oe_n got %b want 1", sram_oe_n); end
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrd_ready got %b want 1", req_ready); end
        if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrd_rd_valid got %b want 0", rd_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) rdv++;
        end
        checks++;
        if (rdv != 0) begin errors++; $display("[TB] FAIL midrd_no_pulse got %0d want 0", rdv); end
        do_read(11'h055, d, lat, pulses);
        checks += 2;
        if (d !== 8'h5A) begin errors++; $display("[TB] FAIL midrd_reread got %h want 5a", d); end
        if (lat != 3) begin errors++; $display("[TB] FAIL midrd_reread_latency got %0d want 3", lat); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        clear_start = 1'b0;
        test_reset;
        test_write_read;
        test_extremes;
        test_write_strobes;
        test_back_to_back;
        test_clear;
        test_reset_mid_read;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
